// File: rtl/my_ram_copier_pkg.sv
// Shared types and default sizes for the RAM copier block.
package my_ram_copier_pkg;

  localparam int unsigned DefAddrW = 9;
  localparam int unsigned DefDataW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StDone
  } copier_state_e;

endpackage

// File: rtl/my_copy_counter.sv
// Source/destination address steppers plus a loadable remaining-word down-counter.
module my_copy_counter
  import my_ram_copier_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] load_src,
  input  logic [ADDR_W-1:0] load_dst,
  input  logic [ADDR_W:0]   load_len,
  output logic [ADDR_W-1:0] cur_src,
  output logic [ADDR_W-1:0] cur_dst,
  output logic              last
);

  logic [ADDR_W-1:0] src_q, dst_q;
  logic [ADDR_W:0]   rem_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q <= '0;
      dst_q <= '0;
      rem_q <= '0;
    end else if (load) begin
      src_q <= load_src;
      dst_q <= load_dst;
      rem_q <= load_len;
    end else if (step) begin
      // Addresses wrap naturally at 2^ADDR_W.
      src_q <= src_q + ADDR_W'(1);
      dst_q <= dst_q + ADDR_W'(1);
      rem_q <= rem_q - (ADDR_W + 1)'(1);
    end
  end

  assign cur_src = src_q;
  assign cur_dst = dst_q;
  // Zero flag of the count after this step.
  assign last    = (rem_q == (ADDR_W + 1)'(1));

endmodule

// File: rtl/my_ram_512.sv
// 512-word RAM: combinational read, posedge write, plus a backdoor port for preload/inspection.
module my_ram_512 #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              load,
  output logic [DATA_W-1:0] dout,
  input  logic              bd_we,
  input  logic [ADDR_W-1:0] bd_addr,
  input  logic [DATA_W-1:0] bd_din,
  output logic [DATA_W-1:0] bd_dout
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // The functional port has priority over the backdoor.
  always_ff @(posedge clk) begin
    if (load) begin
      mem[addr] <= din;
    end else if (bd_we) begin
      mem[bd_addr] <= bd_din;
    end
  end

  assign dout    = mem[addr];
  assign bd_dout = mem[bd_addr];

endmodule

// File: rtl/my_ram_copier.sv
// Word-by-word RAM copy engine (READ/WRITE per word); fill mode is enabled
// with the MY_RAM_COPIER_FILL_EN macro.
module my_ram_copier
  import my_ram_copier_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
  input  logic              fill,
  input  logic [DATA_W-1:0] pattern,
  input  logic [DATA_W-1:0] mem_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_load,
  output logic              busy,
  output logic              done
);

  copier_state_e     state_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] cur_src, cur_dst;
  logic              last;
  logic              accept;
  logic              fill_sel;
  logic              fill_q;

  assign accept = (state_q == StIdle) && start;

`ifdef MY_RAM_COPIER_FILL_EN
  assign fill_sel = fill;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_q <= 1'b0;
    end else if (accept) begin
      fill_q <= fill;
    end
  end
`else
  logic unused_fill;
  assign unused_fill = fill;
  assign fill_sel    = 1'b0;
  assign fill_q      = 1'b0;
`endif

  my_copy_counter #(
    .ADDR_W (ADDR_W)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .step     (state_q == StWrite),
    .load_src (src),
    .load_dst (dst),
    .load_len (len),
    .cur_src  (cur_src),
    .cur_dst  (cur_dst),
    .last     (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      data_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_load <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            if (len == '0) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else if (fill_sel) begin
              // Fill skips READ; the pattern rides in the data register.
              state_q  <= StWrite;
              data_q   <= pattern;
              busy     <= 1'b1;
              mem_load <= 1'b1;
            end else begin
              state_q <= StRead;
              busy    <= 1'b1;
            end
          end
        end
        StRead: begin
          data_q   <= mem_out;
          state_q  <= StWrite;
          mem_load <= 1'b1;
        end
        StWrite: begin
          if (last) begin
            state_q  <= StDone;
            busy     <= 1'b0;
            mem_load <= 1'b0;
            done     <= 1'b1;
          end else if (fill_q) begin
            state_q  <= StWrite;
            mem_load <= 1'b1;
          end else begin
            state_q  <= StRead;
            mem_load <= 1'b0;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q  <= StIdle;
          busy     <= 1'b0;
          mem_load <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr = (state_q == StWrite) ? cur_dst : cur_src;
  assign mem_in   = data_q;

endmodule

// File: tb/tb_my_ram_copier.sv
// Self-checking bench: copier paired with my_ram_512, checked against an array model.
module tb_my_ram_copier;

  localparam int AW = 9;
  localparam int DW = 16;
  localparam int N  = 512;
`ifdef MY_RAM_COPIER_FILL_EN
  localparam bit FillEn = 1'b1;
`else
  localparam bit FillEn = 1'b0;
`endif

  logic          clk, reset, start, fill;
  logic [AW-1:0] src, dst;
  logic [AW:0]   len;
  logic [DW-1:0] pattern, mem_out, mem_in;
  logic [AW-1:0] mem_addr;
  logic          mem_load, busy, done;
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_din, bd_dout;

  logic [DW-1:0] model [N];
  int total = 0;
  int bad   = 0;

  my_ram_copier #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .src      (src),
    .dst      (dst),
    .len      (len),
    .fill     (fill),
    .pattern  (pattern),
    .mem_out  (mem_out),
    .mem_addr (mem_addr),
    .mem_in   (mem_in),
    .mem_load (mem_load),
    .busy     (busy),
    .done     (done)
  );

  my_ram_512 #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) u_ram (
    .clk     (clk),
    .addr    (mem_addr),
    .din     (mem_in),
    .load    (mem_load),
    .dout    (mem_out),
    .bd_we   (bd_we),
    .bd_addr (bd_addr),
    .bd_din  (bd_din),
    .bd_dout (bd_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    bd_we   = 1'b1;
    bd_addr = a;
    bd_din  = d;
    model[a] = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic bd_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
    bd_addr = a;
    #1;
    d = bd_dout;
  endtask

  task automatic compare_ram(input string tag);
    int errs = 0;
    logic [DW-1:0] d;
    for (int i = 0; i < N; i++) begin
      bd_read(AW'(i), d);
      if (d !== model[i]) errs++;
    end
    check({tag, ".ram"}, errs, 0);
  endtask

  // Copy semantics: strictly ascending, one word at a time, so the model is updated word by word.
  task automatic run_xfer(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW:0] l,
                          input logic f, input logic [DW-1:0] p, input string tag);
    bit do_fill;
    int exp_lat, exp_busy, cyc, lat, busy_n, load_n, werr;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;
    do_fill  = f && FillEn;
    exp_lat  = (l == 0) ? 1 : (do_fill ? int'(l) + 1 : 2 * int'(l) + 1);
    exp_busy = do_fill ? int'(l) : 2 * int'(l);
    @(negedge clk);
    src = s; dst = d; len = l; fill = f; pattern = p; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; lat = -1; busy_n = 0; load_n = 0; werr = 0;
    while (cyc <= exp_lat + 8) begin
      if (busy) busy_n++;
      if (mem_load) begin
        if (load_n < int'(l)) begin
          wa = d + AW'(load_n);
          ra = s + AW'(load_n);
          wd = do_fill ? p : model[ra];
          if (mem_addr !== wa || mem_in !== wd) werr++;
          model[wa] = wd;
        end else begin
          werr++;
        end
        load_n++;
      end
      if (done) begin
        lat = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".busy"}, busy_n, exp_busy);
    check({tag, ".loads"}, load_n, int'(l));
    check({tag, ".wr"}, werr, 0);
    @(negedge clk);
    check({tag, ".pulse"}, done, 1'b0);
    compare_ram(tag);
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic [DW-1:0] exp4 [4];
    int loads, dones;
    logic [AW-1:0] rs, rdst;
    logic [AW:0]   rl;

    reset = 1'b1; start = 1'b0; fill = 1'b0; src = '0; dst = '0; len = '0;
    pattern = '0; bd_we = 1'b0; bd_addr = '0; bd_din = '0;
    #1;
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.load", mem_load, 1'b0);
    check("rst.addr", mem_addr, '0);
    check("rst.data", mem_in, '0);

    for (int i = 0; i < N; i++) bd_write(AW'(i), DW'($urandom));
    @(negedge clk);
    reset = 1'b0;

    // Basic copy of four words.
    bd_write(10, 16'hA0A0); bd_write(11, 16'hB1B1);
    bd_write(12, 16'hC2C2); bd_write(13, 16'hD3D3);
    run_xfer(10, 100, 4, 1'b0, 16'h0, "copy4");

    // Zero-length transfer.
    run_xfer(33, 44, 0, 1'b0, 16'h0, "len0");

    // Wrap with overlap: destination sits ahead of the source modulo 512.
    bd_write(510, 16'd1); bd_write(511, 16'd2); bd_write(0, 16'd3); bd_write(1, 16'd4);
    run_xfer(510, 0, 4, 1'b0, 16'h0, "wrap");
    exp4[0] = 16'd1; exp4[1] = 16'd2; exp4[2] = 16'd1; exp4[3] = 16'd2;
    for (int i = 0; i < 4; i++) begin
      bd_read(AW'(i), rd);
      check($sformatf("wrap.w%0d", i), rd, exp4[i]);
    end

    // Reset after the second write of an 8-word copy.
    @(negedge clk);
    src = 20; dst = 300; len = 8; fill = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    loads = 0;
    for (int c = 0; c < 40 && loads < 2; c++) begin
      if (mem_load) begin
        model[AW'(300 + loads)] = model[AW'(20 + loads)];
        loads++;
      end
      if (loads < 2) @(negedge clk);
    end
    check("abort.seen2", loads, 2);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort.busy", busy, 1'b0);
    check("abort.load", mem_load, 1'b0);
    check("abort.done", done, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    compare_ram("abort");
    run_xfer(50, 60, 5, 1'b0, 16'h0, "post_rst");

    // Second start while busy is ignored.
    @(negedge clk);
    src = 40; dst = 70; len = 3; fill = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    src = 80; dst = 90; len = 5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) model[AW'(70 + i)] = model[AW'(40 + i)];
    dones = 0;
    for (int c = 0; c < 24; c++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("dbl.dones", dones, 1);
    compare_ram("dbl");

    // Fill request; a plain copy when fill is compiled out.
    run_xfer(5, 200, 3, 1'b1, 16'hBEEF, "fill");

    // Randomized transfers.
    for (int t = 0; t < 8; t++) begin
      rs   = AW'($urandom);
      rdst = AW'($urandom);
      rl   = (t == 7) ? (AW + 1)'(300) : (AW + 1)'($urandom_range(0, 24));
      run_xfer(rs, rdst, rl, 1'($urandom), DW'($urandom), $sformatf("rnd%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/my_ram_copier.md
MY_RAM_COPIER -- requirements
Module: my_ram_copier

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning the RAM word-address width (512 words).
REQ-002 SHALL have parameter DATA_W, default 16, meaning the RAM word width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on posedge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a one-cycle request to begin a transfer.
REQ-006 SHALL have port src, input, ADDR_W, the first source word address.
REQ-007 SHALL have port dst, input, ADDR_W, the first destination word address.
REQ-008 SHALL have port len, input, ADDR_W+1, the word count (0..512).
REQ-009 SHALL have port fill, input, 1, which selects fill mode instead of copy mode (see Configuration).
REQ-010 SHALL have port pattern, input, DATA_W, the fill value.
REQ-011 SHALL have port mem_out, input, DATA_W, the RAM read data (combinational read of mem_addr).
REQ-012 SHALL have port mem_addr, output, ADDR_W, the RAM address.
REQ-013 SHALL have port mem_in, output, DATA_W, the RAM write data.
REQ-014 SHALL have port mem_load, output, 1, the RAM write enable (RAM writes on posedge clk).
REQ-015 SHALL have port busy, output, 1, high while a transfer is in progress.
REQ-016 SHALL have port done, output, 1, a one-cycle pulse at the end of each accepted transfer.

Function
REQ-017 SHALL implement the states IDLE, READ, WRITE and DONE.
REQ-018 In IDLE, a start at posedge SHALL latch src, dst, len, fill and pattern; it goes to READ if len!=0, else to DONE.
REQ-019 READ SHALL drive mem_addr=cur_src and mem_load=0, capture mem_out into the data register at posedge, and go to WRITE.
REQ-020 WRITE SHALL drive mem_addr=cur_dst, mem_in=data and mem_load=1; at posedge it increments cur_src and cur_dst, decrements remaining, and goes to DONE if remaining was 1, else READ.
REQ-021 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-022 Throughput SHALL be 2 cycles per word; start-to-done latency SHALL be 2*len+1 cycles, or 1 cycle for len=0.
REQ-023 busy SHALL be 1 in READ and WRITE only; mem_load SHALL be 1 in WRITE only.
REQ-024 A start while not in IDLE SHALL be ignored, with no queuing.
REQ-025 Address increments SHALL wrap modulo 2^ADDR_W (511 -> 0).
REQ-026 Overlapping regions SHALL be copied strictly ascending, one word at a time; when dst>src and they overlap, source data is replicated, and this is defined behaviour.
REQ-027 Outside WRITE, mem_in SHALL hold the data register, and mem_addr SHALL hold cur_src.

Reset
REQ-028 Reset SHALL asynchronously force IDLE, busy=0, done=0 and mem_load=0, and clear cur_src, cur_dst, remaining and data to 0.
REQ-029 Reset mid-transfer SHALL abort with no further writes and no done pulse; the first posedge after reset deasserts, it SHALL accept start.

Configuration
REQ-030 With MY_RAM_COPIER_FILL_EN defined, fill=1 SHALL skip READ and write pattern into len words from dst (1 cycle per word, latency len+1); src SHALL be ignored.
REQ-031 Without MY_RAM_COPIER_FILL_EN, fill and pattern SHALL be ignored, and every transfer SHALL be a copy.

Structure
REQ-032 A shared package SHALL hold the state enum (IDLE/READ/WRITE/DONE) and the default ADDR_W/DATA_W constants.
REQ-033 The word-count/address stepping SHALL be one sub-module, my_copy_counter (loadable down-counter with zero flag); everything else SHALL be inline.
REQ-034 The bench SHALL pair the block with my_ram_512 through mem_addr/mem_in/mem_load/mem_out.

Verification
REQ-035 Preload RAM[10..13]=A,B,C,D; start src=10, dst=100, len=4 -> RAM[100..103]=A..D, done 9 cycles after start, busy high 8 cycles.
REQ-036 start with len=0 -> done the next cycle, mem_load never asserted, RAM unchanged.
REQ-037 src=510, dst=0, len=4 with RAM[510,511,0,1]=1,2,3,4 -> wrap verified: final RAM[0..3]=1,2,1,2.
REQ-038 Assert reset after the 2nd write of a len=8 copy -> no further mem_load, no done, busy=0 immediately; a new start then runs normally.
REQ-039 A second start during busy -> ignored, exactly one done pulse.
REQ-040 With MY_RAM_COPIER_FILL_EN defined, fill=1, pattern=16'hBEEF, dst=200, len=3 -> RAM[200..202]=BEEF, done 4 cycles after start; without the macro, the same stimulus performs a copy.
